// File: rtl/rom_read_arbiter_pkg.sv
// Shared types for the program-ROM read arbiter: core count, ROM geometry and word types.
package rom_read_arbiter_pkg;

   localparam int N_CORES   = 4;
   localparam int ROM_DEPTH = 256;
   localparam int ROM_AW    = $clog2(ROM_DEPTH);
   localparam int IR_W      = 16;

   typedef logic [ROM_AW-1:0]          rom_addr_t;
   typedef logic [IR_W-1:0]            ir_word_t;
   typedef logic [$clog2(N_CORES)-1:0] core_id_t;

endpackage

// File: rtl/rom_read_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] idx;

   // Scan from the farthest offset down so the closest requester to ptr is written last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx;
         end
      end
   end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares the single synchronous ROM read port between N_REQ core fetch ports, one
// round-robin grant per cycle, with a programming interlock that flushes in-flight reads.
module rom_read_arbiter
   import rom_read_arbiter_pkg::*;
#(
   parameter int N_REQ  = N_CORES,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        active,
   input  logic [N_REQ*ROM_AW-1:0] addr,
   output logic [N_REQ*IR_W-1:0]   d_out,
   output logic [N_REQ-1:0]        ready,
   input  logic                    prog_busy,
   output logic                    mem_re,
   output logic [ROM_AW-1:0]       mem_addr,
   input  logic [IR_W-1:0]         mem_rd_data,
   output logic                    arb_idle
);

   localparam int IW = $clog2(N_REQ);

   // Core handshake: a core holds active[i] with a stable addr[i]; ready[i] is a level that
   // stays high (d_out[i] valid) until active[i] drops or addr[i] moves away from the served address.
   rom_addr_t        addr_a [N_REQ];
   rom_addr_t        tag    [N_REQ];
   ir_word_t         dout_q [N_REQ];
   logic [N_REQ-1:0] served, inflight, req, release_v, gnt_oh, ret_oh;
   logic [IW-1:0]    rr_ptr, gnt_id, next_ptr;
   logic             gnt_valid, issue;
   logic [RD_LAT:0]  pipe_v;
   logic [IW-1:0]    pipe_id [RD_LAT+1];

   for (genvar g = 0; g < N_REQ; g++) begin : g_core
      assign addr_a[g]              = addr[g*ROM_AW +: ROM_AW];
      assign d_out[g*IR_W +: IR_W]  = dout_q[g];
      assign release_v[g]           = served[g] & (~active[g] | (addr_a[g] != tag[g]));
   end

   assign req      = active & ~served & ~inflight;
   assign issue    = gnt_valid & ~prog_busy;
   assign gnt_oh   = issue ? (N_REQ'(1) << gnt_id) : '0;
   assign ret_oh   = (pipe_v[RD_LAT] & ~prog_busy) ? (N_REQ'(1) << pipe_id[RD_LAT]) : '0;
   assign next_ptr = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
   assign ready    = served;
   assign arb_idle = ~|req & ~|inflight & ~prog_busy;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req       (req),
      .ptr       (rr_ptr),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Stage 0 of the id pipe lines up with mem_re; stage RD_LAT lines up with mem_rd_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         mem_re   <= 1'b0;
         mem_addr <= '0;
         pipe_v   <= '0;
         for (int k = 0; k <= RD_LAT; k++) pipe_id[k] <= '0;
      end else begin
         mem_re     <= issue;
         pipe_v[0]  <= issue;
         pipe_id[0] <= gnt_id;
         for (int k = 1; k <= RD_LAT; k++) begin
            pipe_v[k]  <= pipe_v[k-1] & ~prog_busy;
            pipe_id[k] <= pipe_id[k-1];
         end
         if (issue) begin
            mem_addr <= addr_a[gnt_id];
            rr_ptr   <= next_ptr;
         end
      end
   end

   // A return only becomes ready if the core still wants the very address that was read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         served   <= '0;
         inflight <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            tag[i]    <= '0;
            dout_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (prog_busy) begin
               served[i]   <= 1'b0;
               inflight[i] <= 1'b0;
            end else if (gnt_oh[i]) begin
               inflight[i] <= 1'b1;
               tag[i]      <= addr_a[i];
            end else if (ret_oh[i]) begin
               inflight[i] <= 1'b0;
               served[i]   <= active[i] & (addr_a[i] == tag[i]);
               dout_q[i]   <= mem_rd_data;
            end else if (release_v[i]) begin
               served[i]   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter with a 1-cycle synchronous ROM model.
module tb_rom_read_arbiter;
   import rom_read_arbiter_pkg::*;

   localparam int N = 4;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]        active    = '0;
   rom_addr_t           addr_a [N];
   logic [N*ROM_AW-1:0] addr;
   logic [N*IR_W-1:0]   d_out;
   logic [N-1:0]        ready;
   logic                prog_busy = 1'b0;
   logic                mem_re;
   logic [ROM_AW-1:0]   mem_addr;
   logic [IR_W-1:0]     mem_rd_data = '0;
   logic                arb_idle;

   int n_checks = 0;
   int n_fail   = 0;
   int rom_mult = 3;
   int rom_plus = 1;
   logic [IR_W-1:0] exp_q[$];

   assign addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};

   rom_read_arbiter #(.N_REQ(N), .RD_LAT(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (active),
      .addr        (addr),
      .d_out       (d_out),
      .ready       (ready),
      .prog_busy   (prog_busy),
      .mem_re      (mem_re),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .arb_idle    (arb_idle)
   );

   function automatic ir_word_t rom_word(input rom_addr_t a);
      return IR_W'(int'(a) * rom_mult + rom_plus);
   endfunction

   // ROM array model: read data registered one edge after the strobe
   always @(posedge clk) if (mem_re) mem_rd_data <= rom_word(mem_addr);

   function automatic ir_word_t dout(input int k);
      return d_out[k*IR_W +: IR_W];
   endfunction

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      active    = '0;
      prog_busy = 1'b0;
      for (int k = 0; k < N; k++) addr_a[k] = '0;
      rom_mult  = 3;
      rom_plus  = 1;
      exp_q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(input int core, input int budget, output int cycles);
      cycles = -1;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (ready[core]) begin
            cycles = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < N; k++) addr_a[k] = '0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ready, mem_re, mem_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b mem_re=%b mem_addr=%0d, required all 0", ready, mem_re, mem_addr);
      end
      n_checks++;
      if (d_out !== '0 || arb_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_dout_idle: d_out=%h arb_idle=%b, required 0 and 1", d_out, arb_idle);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      active = 4'hF;
      for (int k = 0; k < N; k++) addr_a[k] = rom_addr_t'(k + 8);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (ready !== '0 || mem_re !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_traffic: ready=%b mem_re=%b, required 0000 and 0", ready, mem_re);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mem_re !== 1'b1 || mem_addr !== rom_addr_t'(8)) begin
         n_fail++;
         $display("FAIL reset_first_grant: mem_re=%b mem_addr=%0d, required 1 and 8", mem_re, mem_addr);
      end
   endtask

   task automatic test_single();
      int   pulses;
      logic held;
      logic [IR_W-1:0] exp;
      do_reset();
      active[0] = 1'b1;
      addr_a[0] = 5;
      exp_q.push_back(rom_word(5));
      pulses = 0;
      held   = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         if (mem_re) pulses++;
         if (n == 2) begin
            n_checks++;
            if (ready[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL single_early_ready: ready0=%b after edge 1, required 0", ready[0]);
            end
         end
         if (n == 3) begin
            n_checks++;
            if (ready[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL single_latency: ready0=%b after edge 2, required 1", ready[0]);
            end
            exp = exp_q.pop_front();
            n_checks++;
            if (dout(0) !== exp) begin
               n_fail++;
               $display("FAIL single_data: d_out0=%0d, required %0d", dout(0), exp);
            end
         end
         if (n > 3 && ready[0] !== 1'b1) held = 1'b0;
      end
      n_checks++;
      if (held !== 1'b1 || pulses !== 1) begin
         n_fail++;
         $display("FAIL single_hold: held=%b mem_re_pulses=%0d, required 1 and 1", held, pulses);
      end
   endtask

   task automatic test_addr_change();
      int cyc;
      logic [IR_W-1:0] exp;
      addr_a[0] = 6;
      exp_q.push_back(rom_word(6));
      @(negedge clk);
      n_checks++;
      if (ready[0] !== 1'b0 || dout(0) !== 16'd16) begin
         n_fail++;
         $display("FAIL addr_change_release: ready0=%b d_out0=%0d, required 0 and 16", ready[0], dout(0));
      end
      wait_ready(0, 10, cyc);
      n_checks++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL addr_change_latency: cycles=%0d, required 3", cyc);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (dout(0) !== exp) begin
         n_fail++;
         $display("FAIL addr_change_data: d_out0=%0d, required %0d", dout(0), exp);
      end
   endtask

   task automatic test_all_cores();
      logic [IR_W-1:0] exp;
      do_reset();
      active = 4'hF;
      for (int k = 0; k < N; k++) begin
         addr_a[k] = rom_addr_t'(k);
         exp_q.push_back(rom_word(rom_addr_t'(k)));
      end
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n <= 4) begin
            n_checks++;
            if (mem_re !== 1'b1 || mem_addr !== rom_addr_t'(n - 1)) begin
               n_fail++;
               $display("FAIL contention_grant%0d: mem_re=%b mem_addr=%0d, required 1 and %0d", n - 1, mem_re, mem_addr, n - 1);
            end
         end
         if (n == 5) begin
            n_checks++;
            if (ready[3] !== 1'b0 || mem_re !== 1'b0) begin
               n_fail++;
               $display("FAIL contention_edge4: ready3=%b mem_re=%b, required 0 and 0", ready[3], mem_re);
            end
         end
         if (n == 6) begin
            n_checks++;
            if (ready !== 4'hF) begin
               n_fail++;
               $display("FAIL contention_ready: ready=%b after edge 5, required 1111", ready);
            end
         end
      end
      for (int k = 0; k < N; k++) begin
         exp = exp_q.pop_front();
         n_checks++;
         if (dout(k) !== exp) begin
            n_fail++;
            $display("FAIL contention_data%0d: d_out=%0d, required %0d", k, dout(k), exp);
         end
      end
      active = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (arb_idle !== 1'b1 || ready !== '0) begin
         n_fail++;
         $display("FAIL contention_drain: arb_idle=%b ready=%b, required 1 and 0000", arb_idle, ready);
      end
   endtask

   task automatic test_fairness();
      int gk[20];
      int gc[20];
      int ng;
      int cyc;
      logic [IR_W-1:0] exp;
      do_reset();
      addr_a[0] = 10;
      addr_a[2] = 20;
      exp_q.push_back(rom_word(10));
      exp_q.push_back(rom_word(20));
      active = 4'b0101;
      ng  = 0;
      cyc = 0;
      while (ng < 20 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_re) begin
            gk[ng] = (mem_addr == rom_addr_t'(10)) ? 0 : 2;
            gc[ng] = cyc;
            ng++;
         end
         for (int i = 0; i < N; i += 2) begin
            if (active[i] && ready[i]) active[i] = 1'b0;
            else if (!active[i])       active[i] = 1'b1;
         end
      end
      n_checks++;
      if (ng !== 20) begin
         n_fail++;
         $display("FAIL fairness_count: grants=%0d in %0d cycles, required 20", ng, cyc);
      end
      for (int j = 0; j < ng; j++) begin
         n_checks++;
         if (gk[j] !== ((j % 2 == 0) ? 0 : 2)) begin
            n_fail++;
            $display("FAIL fairness_order%0d: core=%0d, required %0d", j, gk[j], (j % 2 == 0) ? 0 : 2);
         end
         if (j >= 2) begin
            n_checks++;
            if (gc[j] - gc[j-2] > 4) begin
               n_fail++;
               $display("FAIL fairness_gap%0d: gap=%0d cycles, required <= 4", j, gc[j] - gc[j-2]);
            end
         end
      end
      for (int i = 0; i < N; i += 2) begin
         exp = exp_q.pop_front();
         n_checks++;
         if (dout(i) !== exp) begin
            n_fail++;
            $display("FAIL fairness_data%0d: d_out=%0d, required %0d", i, dout(i), exp);
         end
      end
      active = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_drop_in_flight();
      logic clean;
      logic [IR_W-1:0] exp;
      do_reset();
      active[2] = 1'b1;
      addr_a[2] = 9;
      exp_q.push_back(rom_word(9));
      @(negedge clk);
      n_checks++;
      if (mem_re !== 1'b1 || mem_addr !== rom_addr_t'(9)) begin
         n_fail++;
         $display("FAIL drop_grant: mem_re=%b mem_addr=%0d, required 1 and 9", mem_re, mem_addr);
      end
      active[2] = 1'b0;
      clean = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (ready[2] !== 1'b0) clean = 1'b0;
      end
      n_checks++;
      if (clean !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_ready: ready2 rose after drop, required 0");
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (dout(2) !== exp || arb_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_data: d_out2=%0d arb_idle=%b, required %0d and 1", dout(2), arb_idle, exp);
      end
   endtask

   task automatic test_prog_interlock();
      logic clean;
      int   cyc;
      logic [IR_W-1:0] exp;
      do_reset();
      active[1] = 1'b1;
      addr_a[1] = 7;
      @(negedge clk);
      n_checks++;
      if (mem_re !== 1'b1 || mem_addr !== rom_addr_t'(7)) begin
         n_fail++;
         $display("FAIL prog_grant: mem_re=%b mem_addr=%0d, required 1 and 7", mem_re, mem_addr);
      end
      prog_busy = 1'b1;
      clean = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (ready[1] !== 1'b0 || mem_re !== 1'b0) clean = 1'b0;
         if (n == 1) begin
            n_checks++;
            if (arb_idle !== 1'b0) begin
               n_fail++;
               $display("FAIL prog_idle: arb_idle=%b while prog_busy, required 0", arb_idle);
            end
         end
      end
      n_checks++;
      if (clean !== 1'b1 || dout(1) !== '0) begin
         n_fail++;
         $display("FAIL prog_discard: clean=%b d_out1=%0d, required 1 and 0", clean, dout(1));
      end
      rom_mult = 5;
      rom_plus = 0;
      exp_q.push_back(rom_word(7));
      prog_busy = 1'b0;
      wait_ready(1, 10, cyc);
      n_checks++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL prog_reread_latency: cycles=%0d, required 3", cyc);
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (dout(1) !== exp) begin
         n_fail++;
         $display("FAIL prog_reread_data: d_out1=%0d, required %0d", dout(1), exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_addr_change();
      test_all_cores();
      test_fairness();
      test_drop_in_flight();
      test_prog_interlock();
      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
